// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and defaults for the two-requester ALU front end.
package alu_ctrl_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int SEL_W_DEF  = 3;

   // Controller phases: arbitrate, wait out the ALU pipeline, hold the response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // One requester's operation at the default widths.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] a;
      logic [DATA_W_DEF-1:0] in0;
      logic [DATA_W_DEF-1:0] in1;
      logic [SEL_W_DEF-1:0]  select;
   } alu_req_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner pointer.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic       o_any,
   output logic       o_grant_id
);

   logic r_ptr;
   logic w_grant_id;

   // When both ask, the one the pointer does not name wins; otherwise the sole asker.
   always_comb begin
      w_grant_id = i_valid[1];
      if (&i_valid) begin
         w_grant_id = ~r_ptr;
      end
   end

   // Pointer holds the last accepted winner; reset value 1 lets requester 0 go first.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= 1'b1;
      end else if (i_accept) begin
         r_ptr <= w_grant_id;
      end
   end

   assign o_any      = |i_valid;
   assign o_grant_id = w_grant_id;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, fixed-latency
// wait, then a held response to the winner.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high for the same bit. A requester may drop valid before its transfer
// without penalty; once o_rsp_valid is up, it and o_rsp_data stay put until
// the granted requester's i_rsp_ready is seen high at an edge.
module alu_req_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int ALU_LAT = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [1:0]          i_req_valid,
   output logic [1:0]          o_req_ready,
   input  logic [2*DATA_W-1:0] i_req_A,
   input  logic [2*DATA_W-1:0] i_req_in0,
   input  logic [2*DATA_W-1:0] i_req_in1,
   input  logic [2*SEL_W-1:0]  i_req_select,
   output logic [1:0]          o_rsp_valid,
   input  logic [1:0]          i_rsp_ready,
   output logic [DATA_W-1:0]   o_rsp_data,
   output logic [DATA_W-1:0]   o_alu_A,
   output logic [DATA_W-1:0]   o_alu_in0,
   output logic [DATA_W-1:0]   o_alu_in1,
   output logic [SEL_W-1:0]    o_alu_select,
   input  logic [DATA_W-1:0]   i_alu_out,
   output logic                o_busy,
   output logic                o_grant_id
);

   localparam int CNT_W = $clog2(ALU_LAT + 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_grant;
   logic               r_rsp_valid;
   logic [DATA_W-1:0]  r_result;
   logic [DATA_W-1:0]  r_alu_a;
   logic [DATA_W-1:0]  r_alu_in0;
   logic [DATA_W-1:0]  r_alu_in1;
   logic [SEL_W-1:0]   r_alu_sel;

   logic               w_any;
   logic               w_win;
   logic               w_accept;
   logic [1:0]         w_req_ready;
   logic [DATA_W-1:0]  w_op_a;
   logic [DATA_W-1:0]  w_op_in0;
   logic [DATA_W-1:0]  w_op_in1;
   logic [SEL_W-1:0]   w_op_sel;

   rr_arb2 u_arb (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_valid    (i_req_valid),
      .i_accept   (w_accept),
      .o_any      (w_any),
      .o_grant_id (w_win)
   );

   // Offer ready to the arbitration winner only while idle and out of reset.
   always_comb begin
      w_req_ready = 2'b00;
      if ((r_state == ST_IDLE) && !i_reset && w_any) begin
         w_req_ready = w_win ? 2'b10 : 2'b01;
      end
   end

   assign w_accept = |(w_req_ready & i_req_valid);

   // Pick the winner's operand slice for latching at the accept edge.
   always_comb begin
      w_op_a   = w_win ? i_req_A[2*DATA_W-1 -: DATA_W]      : i_req_A[DATA_W-1:0];
      w_op_in0 = w_win ? i_req_in0[2*DATA_W-1 -: DATA_W]    : i_req_in0[DATA_W-1:0];
      w_op_in1 = w_win ? i_req_in1[2*DATA_W-1 -: DATA_W]    : i_req_in1[DATA_W-1:0];
      w_op_sel = w_win ? i_req_select[2*SEL_W-1 -: SEL_W]   : i_req_select[SEL_W-1:0];
   end

   // Controller: latch on accept, count down the ALU latency, hold the result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_grant     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_result    <= '0;
         r_alu_a     <= '0;
         r_alu_in0   <= '0;
         r_alu_in1   <= '0;
         r_alu_sel   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_alu_a   <= w_op_a;
                  r_alu_in0 <= w_op_in0;
                  r_alu_in1 <= w_op_in1;
                  r_alu_sel <= w_op_sel;
                  r_grant   <= w_win;
                  r_cnt     <= CNT_W'(ALU_LAT);
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Zero count means the ALU output now reflects the latched operands.
               if (r_cnt == '0) begin
                  r_result    <= i_alu_out;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready[r_grant]) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready  = w_req_ready;
   assign o_rsp_valid  = r_rsp_valid ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
   assign o_rsp_data   = r_result;
   assign o_alu_A      = r_alu_a;
   assign o_alu_in0    = r_alu_in0;
   assign o_alu_in1    = r_alu_in1;
   assign o_alu_select = r_alu_sel;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_grant_id   = r_grant;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (ALU latency 1 and 3) share one
// stimulus stream and are checked each cycle against a transaction-level model.
module tb_alu_req_arbiter;
   import alu_ctrl_pkg::*;

   typedef struct {
      string       name;
      logic [63:0] got;
      logic [63:0] exp;
   } pin_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  rsp_ready;
   logic [63:0] req_a;
   logic [63:0] req_in0;
   logic [63:0] req_in1;
   logic [5:0]  req_sel;

   logic [1:0]  d_req_ready [2];
   logic [1:0]  d_rsp_valid [2];
   logic [31:0] d_rsp_data  [2];
   logic [31:0] d_alu_a     [2];
   logic [31:0] d_alu_in0   [2];
   logic [31:0] d_alu_in1   [2];
   logic [2:0]  d_alu_sel   [2];
   logic [31:0] d_alu_out   [2];
   logic        d_busy      [2];
   logic        d_gid       [2];

   int   n_vec = 0;
   int   n_err = 0;
   pin_t pin_q[$];

   // Stand-in ALU behaviour (select 1 is in0+in1; the rest are arbitrary but fixed).
   function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] x, input logic [31:0] y);
      case (s)
         3'd0:    return a;
         3'd1:    return x + y;
         3'd2:    return x - y;
         3'd3:    return x & y;
         3'd4:    return x | y;
         3'd5:    return x ^ y;
         3'd6:    return a + x;
         default: return ~a;
      endcase
   endfunction

   // Clock
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;

      alu_req_arbiter #(.DATA_W(32), .SEL_W(3), .ALU_LAT(L)) dut (
         .i_clk        (clk),
         .i_reset      (rst),
         .i_req_valid  (req_valid),
         .o_req_ready  (d_req_ready[g]),
         .i_req_A      (req_a),
         .i_req_in0    (req_in0),
         .i_req_in1    (req_in1),
         .i_req_select (req_sel),
         .o_rsp_valid  (d_rsp_valid[g]),
         .i_rsp_ready  (rsp_ready),
         .o_rsp_data   (d_rsp_data[g]),
         .o_alu_A      (d_alu_a[g]),
         .o_alu_in0    (d_alu_in0[g]),
         .o_alu_in1    (d_alu_in1[g]),
         .o_alu_select (d_alu_sel[g]),
         .i_alu_out    (d_alu_out[g]),
         .o_busy       (d_busy[g]),
         .o_grant_id   (d_gid[g])
      );

      // L-stage registered ALU
      logic [31:0] pipe [L];
      always @(posedge clk) begin
         pipe[0] <= alu_f(d_alu_sel[g], d_alu_a[g], d_alu_in0[g], d_alu_in1[g]);
         for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
      end
      assign d_alu_out[g] = pipe[L-1];
   end

   // ---------------- reference model + compare process ----------------
   bit          m_init = 1'b0;
   bit          m_busy [2];
   bit          m_rsp  [2];
   bit          m_gid  [2];
   bit          m_ptr  [2];
   int          m_age  [2];
   logic [31:0] m_a    [2];
   logic [31:0] m_x    [2];
   logic [31:0] m_y    [2];
   logic [2:0]  m_s    [2];
   logic [31:0] m_data [2];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   pin_t        p;
   bit          w;
   logic [1:0]  er;
   int          lat;

   always @(negedge clk) begin
      while (pin_q.size() > 0) begin
         p = pin_q.pop_front();
         check(p.name, p.got, p.exp);
      end
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? 1 : 3;
         w   = (&req_valid) ? !m_ptr[k] : req_valid[1];
         er  = (!m_busy[k] && !rst && (|req_valid)) ? (w ? 2'b10 : 2'b01) : 2'b00;
         if (m_init) begin
            check($sformatf("i%0d req_ready", k), 64'(d_req_ready[k]), 64'(er));
            check($sformatf("i%0d rsp_valid", k), 64'(d_rsp_valid[k]),
                  64'(m_rsp[k] ? (m_gid[k] ? 2'b10 : 2'b01) : 2'b00));
            if (m_rsp[k]) check($sformatf("i%0d rsp_data", k), 64'(d_rsp_data[k]), 64'(m_data[k]));
            check($sformatf("i%0d busy", k),     64'(d_busy[k]),    64'(m_busy[k]));
            check($sformatf("i%0d grant_id", k), 64'(d_gid[k]),     64'(m_gid[k]));
            check($sformatf("i%0d alu_A", k),    64'(d_alu_a[k]),   64'(m_a[k]));
            check($sformatf("i%0d alu_in0", k),  64'(d_alu_in0[k]), 64'(m_x[k]));
            check($sformatf("i%0d alu_in1", k),  64'(d_alu_in1[k]), 64'(m_y[k]));
            check($sformatf("i%0d alu_sel", k),  64'(d_alu_sel[k]), 64'(m_s[k]));
         end
         // advance to the state after the coming rising edge
         if (rst) begin
            m_busy[k] = 0; m_rsp[k] = 0; m_gid[k] = 0; m_ptr[k] = 1; m_age[k] = 0;
            m_a[k] = '0; m_x[k] = '0; m_y[k] = '0; m_s[k] = '0; m_data[k] = '0;
         end else if (m_init) begin
            if (!m_busy[k]) begin
               if (|req_valid) begin
                  m_a[k]    = req_a[w*32 +: 32];
                  m_x[k]    = req_in0[w*32 +: 32];
                  m_y[k]    = req_in1[w*32 +: 32];
                  m_s[k]    = req_sel[w*3 +: 3];
                  m_data[k] = alu_f(m_s[k], m_a[k], m_x[k], m_y[k]);
                  m_gid[k]  = w;
                  m_ptr[k]  = w;
                  m_busy[k] = 1;
                  m_age[k]  = 0;
               end
            end else if (!m_rsp[k]) begin
               m_age[k]++;
               if (m_age[k] == lat + 1) m_rsp[k] = 1;
            end else if (rsp_ready[m_gid[k]]) begin
               m_rsp[k]  = 0;
               m_busy[k] = 0;
            end
         end
      end
      if (rst) m_init = 1'b1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string n, input logic [63:0] g, input logic [63:0] e);
      pin_t q;
      q.name = n; q.got = g; q.exp = e;
      pin_q.push_back(q);
   endtask

   task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] x,
                          input logic [31:0] y, input logic [2:0] s);
      req_a[n*32 +: 32]   = a;
      req_in0[n*32 +: 32] = x;
      req_in1[n*32 +: 32] = y;
      req_sel[n*3 +: 3]   = s;
   endtask

   task automatic rand_req(input int n);
      set_req(n, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)));
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      req_valid = 2'b00; rsp_ready = 2'b11;
      repeat (8) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          grants[$];
      int          times[$];
      int          wt;
      bit          seen;
      logic [31:0] ed, ta, tx, ty;
      logic [2:0]  ts;

      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req_a = '0; req_in0 = '0; req_in1 = '0; req_sel = '0;
      repeat (3) tick();

      // 1 + 5: single request, latency 1 and 3 timing
      do_reset();
      set_req(0, 32'hD6, 32'hD4, 32'hD5, 3'd1);
      req_valid = 2'b01;
      #1 pin("t1 ready", 64'(d_req_ready[0]), 64'h1);
      tick();                                          // E0
      req_valid = 2'b00;
      pin("t1 alu_in0", 64'(d_alu_in0[0]), 64'hD4);
      pin("t1 alu_in1", 64'(d_alu_in1[0]), 64'hD5);
      pin("t1 alu_sel", 64'(d_alu_sel[0]), 64'h1);
      tick();                                          // E0+1
      pin("t1 rsp early", 64'(d_rsp_valid[0]), 64'h0);
      tick();                                          // E0+2
      pin("t1 rsp_valid", 64'(d_rsp_valid[0]), 64'h1);
      pin("t1 rsp_data", 64'(d_rsp_data[0]), 64'h1A9);
      rsp_ready = 2'b11;
      tick();                                          // E0+3
      pin("t1 idle again", 64'(d_busy[0]), 64'h0);
      pin("t5 rsp early", 64'(d_rsp_valid[1]), 64'h0);
      tick();                                          // E0+4
      pin("t5 rsp_valid", 64'(d_rsp_valid[1]), 64'h1);
      pin("t5 rsp_data", 64'(d_rsp_data[1]), 64'h1A9);
      drain();

      // 2: fairness under continuous requests
      do_reset();
      rsp_ready = 2'b11; req_valid = 2'b11;
      for (int c = 0; c < 20; c++) begin
         rand_req(0); rand_req(1);
         #1;
         if (d_req_ready[0] != 2'b00) begin
            grants.push_back(int'(d_req_ready[0][1]));
            times.push_back(c);
         end
         tick();
      end
      pin("t2 grant count", 64'(grants.size()), 64'd5);
      if (grants.size() >= 4) begin
         for (int i = 0; i < 4; i++) pin($sformatf("t2 grant %0d", i), 64'(grants[i]), 64'(i % 2));
         for (int i = 0; i < 3; i++) pin($sformatf("t2 spacing %0d", i), 64'(times[i+1] - times[i]), 64'd4);
      end
      drain();

      // 3: response backpressure
      do_reset();
      ta = $urandom; tx = $urandom; ty = $urandom; ts = 3'($urandom_range(0, 7));
      ed = alu_f(ts, ta, tx, ty);
      set_req(0, ta, tx, ty, ts);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      wt = 0;
      while (d_rsp_valid[0] == 2'b00 && wt < 10) begin
         tick();
         wt++;
      end
      pin("t3 rsp arrives", 64'(wt < 10), 64'd1);
      rand_req(1);
      req_valid = 2'b10;
      repeat (5) begin
         #1;
         pin("t3 ready held off", 64'(d_req_ready[0]), 64'h0);
         pin("t3 rsp held", 64'(d_rsp_valid[0]), 64'h1);
         pin("t3 data held", 64'(d_rsp_data[0]), 64'(ed));
         tick();
      end
      rsp_ready = 2'b01;
      tick();
      pin("t3 req1 ready", 64'(d_req_ready[0]), 64'h2);
      tick();
      drain();

      // 4: reset while waiting on the ALU
      do_reset();
      rand_req(0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      rst = 1'b1;
      tick();
      pin("t4 ready", 64'(d_req_ready[0]), 64'h0);
      pin("t4 rsp_valid", 64'(d_rsp_valid[0]), 64'h0);
      pin("t4 rsp_data", 64'(d_rsp_data[0]), 64'h0);
      pin("t4 alu_A", 64'(d_alu_a[0]), 64'h0);
      pin("t4 alu_in0", 64'(d_alu_in0[0]), 64'h0);
      pin("t4 alu_sel", 64'(d_alu_sel[0]), 64'h0);
      pin("t4 busy", 64'(d_busy[0]), 64'h0);
      rst = 1'b0; rsp_ready = 2'b11;
      seen = 1'b0;
      repeat (5) begin
         tick();
         seen |= (d_rsp_valid[0] != 2'b00);
      end
      pin("t4 no response", 64'(seen), 64'h0);
      rand_req(0); rand_req(1);
      req_valid = 2'b11;
      #1 pin("t4 first grant", 64'(d_req_ready[0]), 64'h1);
      tick();
      drain();

      // 6: short-lived request while busy
      do_reset();
      rand_req(0);
      req_valid = 2'b01;
      tick();
      rand_req(1);
      req_valid = 2'b10;
      #1 seen = d_req_ready[0][1];
      tick();
      req_valid = 2'b00; rsp_ready = 2'b11;
      repeat (8) begin
         tick();
         seen |= d_req_ready[0][1];
      end
      pin("t6 ready1 never", 64'(seen), 64'h0);
      pin("t6 grant stays 0", 64'(d_gid[0]), 64'h0);

      // random traffic
      do_reset();
      repeat (3000) begin
         rst       = ($urandom_range(0, 299) == 0);
         req_valid = 2'($urandom_range(0, 3));
         rsp_ready = 2'($urandom_range(0, 3));
         rand_req(0); rand_req(1);
         tick();
      end
      rst = 1'b0;
      drain();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
